// File: rtl/ysyx_23060203_ifu_fetch.sv
// Instruction fetch stage: one outstanding imem request, static backward-branch
// prediction, and a single-entry output holding register toward decode.
module ysyx_23060203_ifu_fetch #(
  parameter int unsigned XLEN     = 32,
  parameter logic [31:0] RESET_PC = 32'h3000_0000
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            flush,
  input  logic [XLEN-1:0] flush_pc,
  input  logic            jump_flush,
  input  logic [XLEN-1:0] jump_dnpc,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_resp_valid,
  input  logic [XLEN-1:0] imem_resp_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_pc,
  output logic [XLEN-1:0] out_inst
);

  localparam logic [1:0] ST_REQ  = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_OUT  = 2'd2;

  localparam logic [XLEN-1:0] ALIGN_MASK = {{(XLEN-2){1'b1}}, 2'b00};
  localparam logic [4:0]      OPC_BRANCH = 5'b11000;

  logic [1:0]      state_q, state_d;
  logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
  logic            hold_valid_q, hold_valid_d;
  logic            drop_q, drop_d;
  logic [XLEN-1:0] out_pc_q, out_pc_d;
  logic [XLEN-1:0] out_inst_q, out_inst_d;

  logic            redirect;
  logic [XLEN-1:0] target;
  logic [XLEN-1:0] imm_b;
  logic            pred_taken;
  logic [XLEN-1:0] pnpc;

  assign redirect = flush | jump_flush;
  assign target   = flush ? flush_pc : jump_dnpc;

  // Static prediction on the arriving response: only backward conditional branches are taken
  assign imm_b = {{(XLEN-12){imem_resp_data[31]}}, imem_resp_data[7],
                  imem_resp_data[30:25], imem_resp_data[11:8], 1'b0};
  assign pred_taken = (imem_resp_data[6:2] == OPC_BRANCH) & imem_resp_data[31];
  assign pnpc       = fetch_pc_q + (pred_taken ? imm_b : XLEN'(4));

  assign imem_req_valid = (state_q == ST_REQ);
  assign imem_req_addr  = fetch_pc_q;
  assign out_valid      = hold_valid_q & ~redirect;
  assign out_pc         = out_pc_q;
  assign out_inst       = out_inst_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q      <= ST_REQ;
      fetch_pc_q   <= RESET_PC;
      hold_valid_q <= 1'b0;
      drop_q       <= 1'b0;
      out_pc_q     <= '0;
      out_inst_q   <= '0;
    end else begin
      state_q      <= state_d;
      fetch_pc_q   <= fetch_pc_d;
      hold_valid_q <= hold_valid_d;
      drop_q       <= drop_d;
      out_pc_q     <= out_pc_d;
      out_inst_q   <= out_inst_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    fetch_pc_d   = fetch_pc_q;
    hold_valid_d = hold_valid_q;
    drop_d       = drop_q;
    out_pc_d     = out_pc_q;
    out_inst_d   = out_inst_q;

    if (redirect) begin
      // Retarget; any request already accepted must have its response dropped
      fetch_pc_d   = target & ALIGN_MASK;
      hold_valid_d = 1'b0;
      case (state_q)
        ST_REQ: begin
          if (imem_req_ready) begin
            drop_d  = 1'b1;
            state_d = ST_WAIT;
          end else begin
            state_d = ST_REQ;
          end
        end
        ST_WAIT: begin
          if (imem_resp_valid) begin
            drop_d  = 1'b0;
            state_d = ST_REQ;
          end else begin
            drop_d  = 1'b1;
            state_d = ST_WAIT;
          end
        end
        default: state_d = ST_REQ;
      endcase
    end else begin
      case (state_q)
        ST_REQ: begin
          if (imem_req_ready) state_d = ST_WAIT;
        end
        ST_WAIT: begin
          if (imem_resp_valid) begin
            if (drop_q) begin
              drop_d  = 1'b0;
              state_d = ST_REQ;
            end else begin
              out_pc_d     = fetch_pc_q;
              out_inst_d   = imem_resp_data;
              hold_valid_d = 1'b1;
              fetch_pc_d   = pnpc;
              state_d      = ST_OUT;
            end
          end
        end
        ST_OUT: begin
          if (out_valid && out_ready) begin
            hold_valid_d = 1'b0;
            state_d      = ST_REQ;
          end
        end
        default: state_d = ST_REQ;
      endcase
    end
  end

  a_resp_only_in_wait: assert property (
    @(posedge clock) disable iff (reset) imem_resp_valid |-> (state_q == ST_WAIT));

endmodule

// File: tb/tb_ysyx_23060203_ifu_fetch.sv
// Directed bench for the fetch stage: prediction table plus redirect, stall and
// reset sequences against a small latency-programmable instruction memory.
module tb_ysyx_23060203_ifu_fetch;

  logic        clock;
  logic        reset;
  logic        flush;
  logic [31:0] flush_pc;
  logic        jump_flush;
  logic [31:0] jump_dnpc;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pc;
  logic [31:0] out_inst;

  int errors = 0;
  int checks = 0;

  ysyx_23060203_ifu_fetch dut (
    .clock          (clock),
    .reset          (reset),
    .flush          (flush),
    .flush_pc       (flush_pc),
    .jump_flush     (jump_flush),
    .jump_dnpc      (jump_dnpc),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_resp_valid(imem_resp_valid),
    .imem_resp_data (imem_resp_data),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_pc         (out_pc),
    .out_inst       (out_inst)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Memory: unlisted addresses read as nop; response appears lat cycles after acceptance
  logic [31:0] mem [logic [31:0]];
  int unsigned lat = 1;
  logic        pend;
  int unsigned cnt;
  logic [31:0] pdata;

  function automatic logic [31:0] mem_read(input logic [31:0] a);
    if (mem.exists(a)) return mem[a];
    return 32'h0000_0013;
  endfunction

  always @(posedge clock or posedge reset) begin
    if (reset) begin
      pend  <= 1'b0;
      cnt   <= 0;
      pdata <= '0;
    end else begin
      if (pend) begin
        if (cnt == 1) pend <= 1'b0;
        else          cnt  <= cnt - 1;
      end
      if (imem_req_valid && imem_req_ready) begin
        pend  <= 1'b1;
        cnt   <= lat;
        pdata <= mem_read(imem_req_addr);
      end
    end
  end

  assign imem_resp_valid = pend && (cnt == 1);
  assign imem_resp_data  = imem_resp_valid ? pdata : 32'h0;

  typedef struct {
    logic [31:0] target;
    logic [31:0] inst;
    logic [31:0] exp_pc;
    logic [31:0] exp_next;
  } vec_t;

  vec_t vecs [9];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Present one request to memory for exactly one clock edge
  task automatic issue();
    imem_req_ready = 1'b1;
    @(negedge clock);
    imem_req_ready = 1'b0;
  endtask

  task automatic wait_out(input string name);
    int n = 0;
    while (!out_valid && n < 20) begin
      @(negedge clock);
      n++;
    end
    check(name, 32'(out_valid), 32'd1);
  endtask

  task automatic handshake();
    out_ready = 1'b1;
    @(negedge clock);
    out_ready = 1'b0;
  endtask

  initial begin
    bit seen_out;
    bit stable;
    int n;

    vecs[0] = '{32'h3000_0010, 32'hFE00_0EE3, 32'h3000_0010, 32'h3000_000C};
    vecs[1] = '{32'h3000_0010, 32'h0000_0463, 32'h3000_0010, 32'h3000_0014};
    vecs[2] = '{32'h3000_0040, 32'hFFDF_F06F, 32'h3000_0040, 32'h3000_0044};
    vecs[3] = '{32'h0000_0000, 32'hFE00_0EE3, 32'h0000_0000, 32'hFFFF_FFFC};
    vecs[4] = '{32'hFFFF_FFFC, 32'h0000_0013, 32'hFFFF_FFFC, 32'h0000_0000};
    vecs[5] = '{32'h3000_1000, 32'h8000_0063, 32'h3000_1000, 32'h3000_0000};
    vecs[6] = '{32'h3000_0400, 32'hFE20_9CE3, 32'h3000_0400, 32'h3000_03F8};
    vecs[7] = '{32'h3000_0023, 32'h8000_0037, 32'h3000_0020, 32'h3000_0024};
    vecs[8] = '{32'h3000_0080, 32'hFE00_0EE7, 32'h3000_0080, 32'h3000_0084};

    reset = 1'b0; flush = 1'b0; flush_pc = '0; jump_flush = 1'b0; jump_dnpc = '0;
    imem_req_ready = 1'b0; out_ready = 1'b0;
    #1 reset = 1'b1;
    #1;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_pc", out_pc, 32'h0);
    check("rst_out_inst", out_inst, 32'h0);
    @(negedge clock);
    @(negedge clock);
    reset = 1'b0;

    // First fetch after reset
    check("boot_req_valid", 32'(imem_req_valid), 32'd1);
    check("boot_req_addr", imem_req_addr, 32'h3000_0000);
    issue();
    wait_out("boot_out_valid");
    check("boot_out_pc", out_pc, 32'h3000_0000);
    check("boot_out_inst", out_inst, 32'h0000_0013);
    handshake();
    check("boot_next_addr", imem_req_addr, 32'h3000_0004);

    // Prediction table: redirect to target, fetch, then inspect the next request
    for (int i = 0; i < 9; i++) begin
      mem[vecs[i].exp_pc] = vecs[i].inst;
      jump_flush = 1'b1;
      jump_dnpc  = vecs[i].target;
      @(negedge clock);
      jump_flush = 1'b0;
      check($sformatf("v%0d_req_addr", i), imem_req_addr, vecs[i].exp_pc);
      issue();
      wait_out($sformatf("v%0d_out_valid", i));
      check($sformatf("v%0d_out_pc", i), out_pc, vecs[i].exp_pc);
      check($sformatf("v%0d_out_inst", i), out_inst, vecs[i].inst);
      handshake();
      check($sformatf("v%0d_next_addr", i), imem_req_addr, vecs[i].exp_next);
      check($sformatf("v%0d_next_valid", i), 32'(imem_req_valid), 32'd1);
    end

    // jump_flush while waiting on a slow response: response must be discarded
    lat = 3;
    issue();
    jump_flush = 1'b1;
    jump_dnpc  = 32'h3000_0100;
    @(negedge clock);
    jump_flush = 1'b0;
    check("drop_still_wait", 32'(imem_req_valid), 32'd0);
    seen_out = 1'b0;
    n = 0;
    while (!imem_req_valid && n < 10) begin
      if (out_valid) seen_out = 1'b1;
      @(negedge clock);
      n++;
    end
    check("drop_req_valid", 32'(imem_req_valid), 32'd1);
    check("drop_no_out", 32'(seen_out), 32'd0);
    check("drop_req_addr", imem_req_addr, 32'h3000_0100);
    lat = 1;

    // flush and jump_flush together in OUT with decode ready: flush wins, no handshake
    issue();
    wait_out("both_out_valid");
    check("both_out_pc", out_pc, 32'h3000_0100);
    out_ready  = 1'b1;
    flush      = 1'b1;
    flush_pc   = 32'h3000_0200;
    jump_flush = 1'b1;
    jump_dnpc  = 32'h3000_0300;
    #1;
    check("both_mask", 32'(out_valid), 32'd0);
    @(negedge clock);
    out_ready = 1'b0; flush = 1'b0; jump_flush = 1'b0;
    check("both_req_valid", 32'(imem_req_valid), 32'd1);
    check("both_req_addr", imem_req_addr, 32'h3000_0200);
    check("both_out_cleared", 32'(out_valid), 32'd0);

    // Decode stalled for 5 cycles: output held, no new request
    mem[32'h3000_0200] = 32'h00A0_0093;
    issue();
    wait_out("stall_out_valid");
    stable = 1'b1;
    for (int c = 0; c < 5; c++) begin
      if (!out_valid || out_pc !== 32'h3000_0200 || out_inst !== 32'h00A0_0093 || imem_req_valid)
        stable = 1'b0;
      @(negedge clock);
    end
    check("stall_hold", 32'(stable), 32'd1);
    handshake();
    check("stall_next_addr", imem_req_addr, 32'h3000_0204);

    // Asynchronous reset while waiting on memory
    lat = 3;
    issue();
    #2 reset = 1'b1;
    #1;
    check("areset_out_valid", 32'(out_valid), 32'd0);
    check("areset_out_pc", out_pc, 32'h0);
    check("areset_req_addr", imem_req_addr, 32'h3000_0000);
    @(negedge clock);
    reset = 1'b0;
    lat = 1;
    check("areset_req_valid", 32'(imem_req_valid), 32'd1);
    issue();
    wait_out("areset_out_valid2");
    check("areset_refetch_pc", out_pc, 32'h3000_0000);
    handshake();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
